// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - arbiter/sequencer for the machine-mode CSR file port (instruction RMW and trap entry)
// Optional macro CSR_RO_PROTECT_EN: makes 0xF11-0xF14 read-only for instruction accesses.
module csr_access_ctrl #(
   parameter int XLEN                = 32,
   parameter int CSR_AW              = 32,
   parameter int VEC_MODE_EN_DEFAULT = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [11:0]       req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              rsp_valid_o,
   output logic [XLEN-1:0]   rsp_rdata_o,
   output logic              rsp_illegal_o,
   input  logic              trap_valid_i,
   input  logic [XLEN-1:0]   trap_cause_i,
   input  logic [XLEN-1:0]   trap_pc_i,
   output logic              trap_done_o,
   output logic [XLEN-1:0]   trap_vec_o,
   output logic [CSR_AW-1:0] csr_addr_o,
   output logic              csr_we_o,
   output logic              csr_re_o,
   output logic [XLEN-1:0]   csr_wdata_o,
   input  logic [XLEN-1:0]   csr_rdata_i
);

   typedef enum logic [3:0] {
      IDLE, I_RD, I_MOD, I_RSP,
      T_EPC, T_CAUSE, T_ST_RD, T_ST_WR, T_VEC_RD, T_DONE
   } state_t;

   localparam logic [1:0] OP_RD = 2'b00;
   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;

   state_t            state, state_n;
   logic [1:0]        op_q;
   logic [11:0]       addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic              illegal_q;
   logic [XLEN-1:0]   cause_q;
   logic [XLEN-3:0]   pc_q;
   logic [XLEN-1:0]   rsp_rdata_q;
   logic              rsp_illegal_q;

   logic              req_illegal;
   logic              ro_viol;
   logic              do_write;
   logic [XLEN-1:0]   mod_val;
   logic [XLEN-1:0]   st_new;
   logic [XLEN-1:0]   vec_base;
   logic [XLEN-1:0]   vec_val;
   logic [11:0]       addr_s;
   logic [XLEN-1:0]   wdata_s;
   logic              re_s, we_s;

   function automatic logic is_impl(input logic [11:0] a);
      case (a)
         12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h342, 12'h300,
         12'h305, 12'h341, 12'h344, 12'h304, 12'hB00, 12'hB80, 12'hB02,
         12'hB82, 12'h306: is_impl = 1'b1;
         default:          is_impl = 1'b0;
      endcase
   endfunction

`ifdef CSR_RO_PROTECT_EN
   assign ro_viol = (req_addr_i >= 12'hF11) && (req_addr_i <= 12'hF14) &&
                    ((req_op_i == OP_RW) || (req_op_i[1] && (req_wdata_i != '0)));
`else
   assign ro_viol = 1'b0;
`endif

   assign req_illegal = ~is_impl(req_addr_i) | ro_viol;
   assign req_ready_o = (state == IDLE) & ~trap_valid_i & ~rst_i;

   // Set/clear with an empty mask are pure reads and must not touch the file.
   assign do_write = (op_q == OP_RW) || (op_q[1] && (wdata_q != '0));

   always_comb begin
      case (op_q)
         OP_RW:   mod_val = wdata_q;
         OP_RS:   mod_val = csr_rdata_i | wdata_q;
         OP_RD:   mod_val = csr_rdata_i;
         default: mod_val = csr_rdata_i & ~wdata_q;
      endcase
   end

   always_comb begin
      st_new        = csr_rdata_i;
      st_new[7]     = csr_rdata_i[3];
      st_new[3]     = 1'b0;
      st_new[12:11] = 2'b11;
   end

   assign vec_base = {csr_rdata_i[XLEN-1:2], 2'b00};
   assign vec_val  = ((VEC_MODE_EN_DEFAULT != 0) && (csr_rdata_i[1:0] == 2'b01) && cause_q[XLEN-1])
                     ? vec_base + XLEN'({cause_q[4:0], 2'b00}) : vec_base;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         op_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         illegal_q     <= 1'b0;
         cause_q       <= '0;
         pc_q          <= '0;
         rsp_rdata_q   <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && trap_valid_i) begin
            cause_q <= trap_cause_i;
            pc_q    <= trap_pc_i[XLEN-1:2];
         end else if (req_valid_i && req_ready_o) begin
            op_q      <= req_op_i;
            addr_q    <= req_addr_i;
            wdata_q   <= req_wdata_i;
            illegal_q <= req_illegal;
         end
         if (state == I_MOD) begin
            rsp_rdata_q   <= illegal_q ? '0 : csr_rdata_i;
            rsp_illegal_q <= illegal_q;
         end
      end
   end

   always_comb begin
      state_n     = state;
      re_s        = 1'b0;
      we_s        = 1'b0;
      addr_s      = '0;
      wdata_s     = '0;
      rsp_valid_o = 1'b0;
      trap_done_o = 1'b0;
      trap_vec_o  = '0;
      case (state)
         IDLE: begin
            if (trap_valid_i)     state_n = T_EPC;
            else if (req_valid_i) state_n = I_RD;
         end
         I_RD: begin
            re_s    = ~illegal_q;
            addr_s  = illegal_q ? 12'h000 : addr_q;
            state_n = I_MOD;
         end
         I_MOD: begin
            if (!illegal_q && do_write) begin
               we_s    = 1'b1;
               addr_s  = addr_q;
               wdata_s = mod_val;
            end
            state_n = I_RSP;
         end
         I_RSP: begin
            rsp_valid_o = 1'b1;
            state_n     = IDLE;
         end
         T_EPC: begin
            we_s    = 1'b1;
            addr_s  = 12'h341;
            wdata_s = {pc_q, 2'b00};
            state_n = T_CAUSE;
         end
         T_CAUSE: begin
            we_s    = 1'b1;
            addr_s  = 12'h342;
            wdata_s = cause_q;
            state_n = T_ST_RD;
         end
         T_ST_RD: begin
            re_s    = 1'b1;
            addr_s  = 12'h300;
            state_n = T_ST_WR;
         end
         T_ST_WR: begin
            we_s    = 1'b1;
            addr_s  = 12'h300;
            wdata_s = st_new;
            state_n = T_VEC_RD;
         end
         T_VEC_RD: begin
            re_s    = 1'b1;
            addr_s  = 12'h305;
            state_n = T_DONE;
         end
         T_DONE: begin
            trap_done_o = 1'b1;
            trap_vec_o  = vec_val;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // The file's write beats its own reset, so strobes must drop in the reset cycle itself.
      if (rst_i) begin
         re_s        = 1'b0;
         we_s        = 1'b0;
         addr_s      = '0;
         wdata_s     = '0;
         rsp_valid_o = 1'b0;
         trap_done_o = 1'b0;
         trap_vec_o  = '0;
      end
   end

   assign csr_re_o      = re_s;
   assign csr_we_o      = we_s;
   assign csr_addr_o    = CSR_AW'(addr_s);
   assign csr_wdata_o   = wdata_s;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb/tb_csr_access_ctrl.sv - scoreboard bench for csr_access_ctrl with a behavioural CSR file
module tb_csr_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [11:0] req_addr = 12'h000;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_illegal;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_cause = 32'h0;
   logic [31:0] trap_pc = 32'h0;
   logic        trap_done;
   logic [31:0] trap_vec;
   logic [31:0] csr_addr;
   logic        csr_we;
   logic        csr_re;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata = 32'h0;

   csr_access_ctrl #(.XLEN(32), .CSR_AW(32), .VEC_MODE_EN_DEFAULT(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal),
      .trap_valid_i(trap_valid), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
      .trap_done_o(trap_done), .trap_vec_o(trap_vec),
      .csr_addr_o(csr_addr), .csr_we_o(csr_we), .csr_re_o(csr_re),
      .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata)
   );

   always #5 clk = ~clk;

   // CSR file: registered read, write wins over nothing else here.
   bit [31:0] mem [4096];
   always @(posedge clk) begin
      if (csr_we) mem[csr_addr[11:0]] <= csr_wdata;
      if (csr_re) csr_rdata <= mem[csr_addr[11:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] rdata; logic ill; int cyc; } rsp_t;
   typedef struct { logic [31:0] vec; int cyc; } trap_t;
   rsp_t  rsp_q[$];
   trap_t trap_q[$];
   rsp_t  rsp_e;
   trap_t trap_e;

   int n_pass = 0, n_total = 0;
   int viol = 0, re_cnt = 0, we_cnt = 0;
   int hs_cyc = 0, done_cyc = 0;
   int re0, we0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_total++;
      $display("FAIL %s", name);
   endtask

   // Monitor: strobe rules plus scoreboard pops.
   always @(negedge clk) begin
      if (csr_re && csr_we) viol++;
      if (!csr_re && !csr_we && csr_addr != 32'h0) viol++;
      if (csr_addr[31:12] != 20'h0) viol++;
      if (csr_re) re_cnt++;
      if (csr_we) we_cnt++;
      if (rsp_valid) begin
         if (rsp_q.size() == 0) fail("rsp_unexpected");
         else begin
            rsp_e = rsp_q.pop_front();
            check("rsp_rdata", rsp_rdata, rsp_e.rdata);
            check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, rsp_e.ill});
            check("rsp_latency", cyc, rsp_e.cyc);
         end
      end
      if (trap_done) begin
         if (trap_q.size() == 0) fail("trap_done_unexpected");
         else begin
            trap_e = trap_q.pop_front();
            check("trap_vec", trap_vec, trap_e.vec);
            check("trap_latency", cyc, trap_e.cyc);
         end
      end
   end

   task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_ill);
      bit ok = 0;
      req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1;
            hs_cyc = cyc;
            rsp_q.push_back('{exp_rd, exp_ill, cyc + 3});
         end
      end
      if (!ok) fail("req_handshake_timeout");
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Caller guarantees the DUT is idle so the trap is accepted in the first cycle.
   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] exp_vec);
      bit ok = 0;
      trap_cause = cause; trap_pc = pc; trap_valid = 1'b1;
      @(negedge clk);
      trap_q.push_back('{exp_vec, cyc + 6});
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         if (trap_done) begin
            ok = 1;
            done_cyc = cyc;
         end
      end
      if (!ok) fail("trap_done_timeout");
      @(posedge clk); #1;
      trap_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (rsp_q.size() == 0 && trap_q.size() == 0) ok = 1;
      end
      if (!ok) fail("drain_timeout");
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_we_re", {30'd0, csr_we, csr_re}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("idle_outputs", {29'd0, rsp_valid, rsp_illegal, trap_done}, 32'd0);
      check("idle_rdata", rsp_rdata, 32'h0);
      check("idle_addr", csr_addr, 32'h0);
      @(posedge clk); #1;

      // mtvec write and read-back
      do_req(2'b01, 12'h305, 32'h8000_0100, 32'h0, 1'b0);
      do_req(2'b00, 12'h305, 32'h0, 32'h8000_0100, 1'b0);
      wait_idle();
      check("mtvec_mem", mem[12'h305], 32'h8000_0100);

      // set/clear on mie
      do_req(2'b01, 12'h304, 32'h0000_00F0, 32'h0, 1'b0);
      do_req(2'b10, 12'h304, 32'h0000_000F, 32'h0000_00F0, 1'b0);
      wait_idle();
      check("mie_after_rs", mem[12'h304], 32'h0000_00FF);
      do_req(2'b11, 12'h304, 32'h0000_00F0, 32'h0000_00FF, 1'b0);
      wait_idle();
      check("mie_after_rc", mem[12'h304], 32'h0000_000F);

      // RS with empty mask: read only
      re0 = re_cnt; we0 = we_cnt;
      do_req(2'b10, 12'h304, 32'h0, 32'h0000_000F, 1'b0);
      wait_idle();
      check("rs0_reads", re_cnt - re0, 32'd1);
      check("rs0_writes", we_cnt - we0, 32'd0);

      // unimplemented address
      re0 = re_cnt; we0 = we_cnt;
      do_req(2'b01, 12'h123, 32'hDEAD_BEEF, 32'h0, 1'b1);
      wait_idle();
      check("illegal_reads", re_cnt - re0, 32'd0);
      check("illegal_writes", we_cnt - we0, 32'd0);

      // vectored trap
      do_req(2'b01, 12'h305, 32'h0000_1001, 32'h8000_0100, 1'b0);
      do_req(2'b01, 12'h300, 32'h0000_0008, 32'h0, 1'b0);
      wait_idle();
      do_trap(32'h8000_0007, 32'h0000_2006, 32'h0000_101C);
      wait_idle();
      check("mepc", mem[12'h341], 32'h0000_2004);
      check("mcause", mem[12'h342], 32'h8000_0007);
      check("mstatus", mem[12'h300], 32'h0000_1880);

      // synchronous cause ignores vectoring
      do_trap(32'h0000_0007, 32'h0000_3002, 32'h0000_1000);
      wait_idle();
      check("mepc2", mem[12'h341], 32'h0000_3000);
      check("mstatus2", mem[12'h300], 32'h0000_1800);

      // trap and request raised together: trap first
      fork
         do_trap(32'h8000_000B, 32'h0000_4000, 32'h0000_102C);
         do_req(2'b00, 12'h342, 32'h0, 32'h8000_000B, 1'b0);
      join
      check("ready_after_done", hs_cyc, done_cyc + 1);
      wait_idle();

      // reset in T_ST_WR
      trap_cause = 32'h8000_0003; trap_pc = 32'h0000_5000; trap_valid = 1'b1;
      @(negedge clk);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      trap_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_we", {31'd0, csr_we}, 32'd0);
      check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);
      check("post_rst_strobes", {30'd0, csr_we, csr_re}, 32'd0);
      check("rst_mstatus", mem[12'h300], 32'h0000_1800);
      check("rst_mcause", mem[12'h342], 32'h8000_0003);
      @(posedge clk); #1;

`ifdef CSR_RO_PROTECT_EN
      do_req(2'b01, 12'hF14, 32'h5, 32'h0, 1'b1);
      do_req(2'b11, 12'hF14, 32'h0, 32'h0, 1'b0);
      wait_idle();
      check("mhartid_ro", mem[12'hF14], 32'h0);
`else
      do_req(2'b01, 12'hF14, 32'h5, 32'h0, 1'b0);
      do_req(2'b11, 12'hF14, 32'h0, 32'h5, 1'b0);
      wait_idle();
      check("mhartid_rw", mem[12'hF14], 32'h5);
`endif

      repeat (2) @(posedge clk);
      check("strobe_rules", viol, 32'd0);
      check("rsp_queue_empty", rsp_q.size(), 32'd0);
      check("trap_queue_empty", trap_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequencer and arbiter in front of the 16-entry machine-mode CSR register file.
- Shares the file's single read/write port between two requesters: the core's CSR-instruction port and the trap unit.
- Instruction port: atomic read-modify-write for CSRRW, CSRRS and CSRRC.
- Trap port: fixed trap-entry sequence (mepc, mcause, mstatus update, mtvec fetch) that returns the handler address.

Parameters:
- XLEN, 32, data width of CSRs and of every data port.
- CSR_AW, 32, width of the CSR file address bus; the upper bits above 12 are driven 0.
- VEC_MODE_EN_DEFAULT, 1, 1 = honour mtvec.MODE = 1 (vectored); 0 = always direct.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  CSR instruction request
- req_ready_o  out  1  request accepted when valid & ready
- req_op_i  in  2  01 = RW, 10 = RS, 11 = RC, 00 = read-only
- req_addr_i  in  12  CSR address
- req_wdata_i  in  XLEN  write value or bit mask
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  XLEN  old CSR value
- rsp_illegal_o  out  1  access faulted
- trap_valid_i  in  1  trap entry request, level, held until trap_done_o
- trap_cause_i  in  XLEN  mcause value
- trap_pc_i  in  XLEN  mepc value
- trap_done_o  out  1  one-cycle pulse
- trap_vec_o  out  XLEN  handler PC, valid with trap_done_o
- csr_addr_o  out  CSR_AW  to CSR file
- csr_we_o  out  1  to CSR file write enable
- csr_re_o  out  1  to CSR file read enable
- csr_wdata_o  out  XLEN  to CSR file write data
- csr_rdata_i  in  XLEN  from CSR file; registered, valid the cycle after csr_re_o

Behaviour:
- Reset:
  - While rst_i = 1, state goes to IDLE next edge.
  - csr_we_o and csr_re_o are combinationally forced to 0 while rst_i = 1, because the file's write has priority over its reset.
  - All other outputs are 0 out of reset. Reset mid-sequence aborts with no response or done pulse.
- Implemented addresses: 0x301, 0xF11–0xF14, 0x342, 0x300, 0x305, 0x341, 0x344, 0x304, 0xB00, 0xB80, 0xB02, 0xB82, 0x306. Any other address is illegal.
- Arbitration (IDLE only): trap_valid_i beats req_valid_i. req_ready_o = (state == IDLE) & ~trap_valid_i & ~rst_i.
- FSM, instruction path: IDLE -> I_RD -> I_MOD -> I_RSP -> IDLE.
  - I_RD: csr_re_o = 1, csr_addr_o = addr.
  - I_MOD: old = csr_rdata_i, which is latched into rsp_rdata_o.
    - new value: RW = wdata, RS = old | wdata, RC = old & ~wdata.
    - csr_we_o = 1 with new, except: op 00; RS/RC with wdata = 0; illegal address.
  - I_RSP: rsp_valid_o = 1 for exactly one cycle.
  - Latency: handshake at edge N -> rsp_valid_o high in cycle N+3. Throughput: 1 request per 4 cycles.
  - Illegal address: no read or write strobes, rsp_illegal_o = 1, rsp_rdata_o = 0. The path still returns in 3 cycles.
- FSM, trap path: IDLE -> T_EPC -> T_CAUSE -> T_ST_RD -> T_ST_WR -> T_VEC_RD -> T_DONE -> IDLE.
  - T_EPC: write 0x341 = {pc[31:2], 2'b00}.
  - T_CAUSE: write 0x342 = cause.
  - T_ST_RD: read 0x300.
  - T_ST_WR: write 0x300 = old with bit7 (MPIE) = old bit3, bit3 (MIE) = 0, bits 12:11 (MPP) = 2'b11.
  - T_VEC_RD: read 0x305.
  - T_DONE: trap_done_o = 1; trap_vec_o computed from mtvec:
    - mtvec[1:0] == 01, cause[31] = 1 and VEC_MODE_EN_DEFAULT = 1: {mtvec[31:2], 2'b00} + 4*cause[4:0].
    - Otherwise: {mtvec[31:2], 2'b00}.
  - Trap latency: accept edge N -> trap_done_o in cycle N+6. The 32-bit add wraps modulo 2^32.
- Request held during a trap: it is not accepted until the trap completes and state is IDLE again.
- Strobes: csr_re_o and csr_we_o are never high in the same cycle. csr_addr_o is 0 when neither strobe is high.

Optional Feature:
- CSR_RO_PROTECT_EN.
  - Defined: addresses 0xF11–0xF14 are read-only. An instruction access with a write intent (RW, or RS/RC with nonzero wdata) is illegal: rsp_illegal_o = 1, no write, rsp_rdata_o = 0, latency unchanged. Reads (op 00, or RS/RC with wdata = 0) stay legal.
  - Undefined: these addresses are writable like any other implemented CSR.

Test Plan:
- RW 0x305, wdata 0x8000_0100, then op 00 on 0x305 -> second rsp_rdata_o = 0x8000_0100, each rsp_valid_o 3 cycles after its handshake.
- mie (0x304) = 0x0000_00F0, RS wdata 0x0F -> rsp_rdata_o = 0xF0, mie = 0xFF. Then RC wdata 0xF0 -> rsp_rdata_o = 0xFF, mie = 0x0F.
- Address 0x123, RW 0xDEAD_BEEF -> rsp_illegal_o = 1, rsp_rdata_o = 0, csr_we_o and csr_re_o never asserted.
- mtvec = 0x0000_1001, mstatus = 0x8, trap cause 0x8000_0007, pc 0x0000_2006 -> mepc = 0x2004, mcause = 0x8000_0007, mstatus = 0x1880, trap_vec_o = 0x101C, trap_done_o 6 cycles after accept.
- trap_valid_i and req_valid_i rise together -> trap sequence runs first. req_ready_o is first high in the cycle after trap_done_o, and the request response follows 3 cycles after that handshake.
- rst_i asserted in T_ST_WR -> csr_we_o = 0 that cycle, no trap_done_o, state IDLE next cycle. With CSR_RO_PROTECT_EN defined, RW 0xF14 = 5 -> rsp_illegal_o = 1 and mhartid unchanged.
